// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: state encodings and default widths for the hazard controller
package pipeline_hazard_ctrl_pkg;
  localparam int HC_AWIDTH = 5;
  localparam int HC_CNT_WIDTH = 16;
  typedef enum logic [1:0] {
    HC_RUN        = 2'd0,
    HC_LOAD_STALL = 2'd1,
    HC_MD_WAIT    = 2'd2
  } hc_state_e;
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: decode/execute status in, pipeline-register controls out
interface pipeline_hazard_ctrl_if
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int AWIDTH    = HC_AWIDTH,
  parameter int CNT_WIDTH = HC_CNT_WIDTH
);
  logic                 hc_i_id_ce;
  logic [AWIDTH-1:0]    hc_i_id_rs;
  logic [AWIDTH-1:0]    hc_i_id_rt;
  logic                 hc_i_id_uses_rt;
  logic                 hc_i_id_md_start;
  logic                 hc_i_id_hilo_rd;
  logic                 hc_i_ex_ce;
  logic                 hc_i_ex_mem_read;
  logic [AWIDTH-1:0]    hc_i_ex_rd;
  logic                 hc_i_ex_change_pc;
  logic                 hc_o_pc_stall;
  logic                 hc_o_ifid_stall;
  logic                 hc_o_ifid_flush;
  logic                 hc_o_idex_bubble;
  logic                 hc_o_md_busy;
  logic [1:0]           hc_o_state;
  logic [CNT_WIDTH-1:0] hc_o_stall_cnt;
  modport master (
    output hc_i_id_ce, hc_i_id_rs, hc_i_id_rt, hc_i_id_uses_rt, hc_i_id_md_start,
           hc_i_id_hilo_rd, hc_i_ex_ce, hc_i_ex_mem_read, hc_i_ex_rd, hc_i_ex_change_pc,
    input  hc_o_pc_stall, hc_o_ifid_stall, hc_o_ifid_flush, hc_o_idex_bubble,
           hc_o_md_busy, hc_o_state, hc_o_stall_cnt
  );
  modport slave (
    input  hc_i_id_ce, hc_i_id_rs, hc_i_id_rt, hc_i_id_uses_rt, hc_i_id_md_start,
           hc_i_id_hilo_rd, hc_i_ex_ce, hc_i_ex_mem_read, hc_i_ex_rd, hc_i_ex_change_pc,
    output hc_o_pc_stall, hc_o_ifid_stall, hc_o_ifid_flush, hc_o_idex_bubble,
           hc_o_md_busy, hc_o_state, hc_o_stall_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use and MULT/DIV hazard compare
module hazard_detect #(
  parameter int AWIDTH = 5
) (
  input  logic              i_id_ce,
  input  logic [AWIDTH-1:0] i_id_rs,
  input  logic [AWIDTH-1:0] i_id_rt,
  input  logic              i_id_uses_rt,
  input  logic              i_id_md_start,
  input  logic              i_id_hilo_rd,
  input  logic              i_ex_ce,
  input  logic              i_ex_mem_read,
  input  logic [AWIDTH-1:0] i_ex_rd,
  input  logic              i_md_busy,
  output logic              o_luh,
  output logic              o_mdh
);
  assign o_luh = i_id_ce & i_ex_ce & i_ex_mem_read & (i_ex_rd != '0) &
                 ((i_ex_rd == i_id_rs) | (i_id_uses_rt & (i_ex_rd == i_id_rt)));
  assign o_mdh = i_md_busy & i_id_ce & (i_id_md_start | i_id_hilo_rd);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stalls, branch flushes and MULT/DIV busy window around execute
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int AWIDTH         = HC_AWIDTH,
  parameter int LOAD_STALL_CYC = 1,
  parameter int MD_LATENCY     = 32,
  parameter int CNT_WIDTH      = HC_CNT_WIDTH
) (
  input  logic                 hc_i_clk,
  input  logic                 hc_i_rst,
  pipeline_hazard_ctrl_if.slave hc
);
  localparam int LW = $clog2(LOAD_STALL_CYC + 1);
  localparam int MW = $clog2(MD_LATENCY);
  hc_state_e            r_state, w_state_nxt;
  logic [LW-1:0]        r_ld_cnt, w_ld_nxt;
  logic [MW-1:0]        r_md_cnt, w_md_nxt;
  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic                 w_luh, w_mdh, w_cp, w_pend, w_stall, w_md_go, w_md_busy;
  assign w_md_busy = r_state == HC_MD_WAIT;
  hazard_detect #(.AWIDTH(AWIDTH)) u_hd (
    .i_id_ce      (hc.hc_i_id_ce),
    .i_id_rs      (hc.hc_i_id_rs),
    .i_id_rt      (hc.hc_i_id_rt),
    .i_id_uses_rt (hc.hc_i_id_uses_rt),
    .i_id_md_start(hc.hc_i_id_md_start),
    .i_id_hilo_rd (hc.hc_i_id_hilo_rd),
    .i_ex_ce      (hc.hc_i_ex_ce),
    .i_ex_mem_read(hc.hc_i_ex_mem_read),
    .i_ex_rd      (hc.hc_i_ex_rd),
    .i_md_busy    (w_md_busy),
    .o_luh        (w_luh),
    .o_mdh        (w_mdh)
  );
  // A non-zero load counter means stall cycles are still owed, in LOAD_STALL or alongside MD_WAIT
  always_comb begin
    w_cp        = hc.hc_i_ex_change_pc;
    w_pend      = r_ld_cnt != '0;
    w_stall     = !w_cp & (w_pend | w_mdh | w_luh);
    w_md_go     = (r_state == HC_RUN) & hc.hc_i_id_ce & hc.hc_i_id_md_start & !w_stall & !w_cp;
    w_ld_nxt    = w_cp ? '0 : w_pend ? r_ld_cnt - LW'(1) :
                  (w_luh & !w_mdh) ? LW'(LOAD_STALL_CYC - 1) : '0;
    w_md_nxt    = w_md_busy ? ((r_md_cnt != '0) ? r_md_cnt - MW'(1) : '0) :
                  w_md_go ? MW'(MD_LATENCY - 1) : '0;
    w_state_nxt = ((w_md_busy && r_md_cnt != '0) || w_md_go) ? HC_MD_WAIT :
                  (w_ld_nxt != '0) ? HC_LOAD_STALL : HC_RUN;
  end
  always_ff @(posedge hc_i_clk) begin
    if (hc_i_rst) begin
      r_state     <= HC_RUN;
      r_ld_cnt    <= '0;
      r_md_cnt    <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ld_cnt    <= w_ld_nxt;
      r_md_cnt    <= w_md_nxt;
      r_stall_cnt <= (w_stall && !(&r_stall_cnt)) ? r_stall_cnt + CNT_WIDTH'(1) : r_stall_cnt;
    end
  end
  assign hc.hc_o_pc_stall    = !hc_i_rst & w_stall;
  assign hc.hc_o_ifid_stall  = !hc_i_rst & w_stall;
  assign hc.hc_o_ifid_flush  = !hc_i_rst & w_cp;
  assign hc.hc_o_idex_bubble = !hc_i_rst & (w_stall | w_cp);
  assign hc.hc_o_md_busy     = !hc_i_rst & w_md_busy;
  assign hc.hc_o_state       = hc_i_rst ? HC_RUN : r_state;
  assign hc.hc_o_stall_cnt   = hc_i_rst ? '0 : r_stall_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vectors, expected outputs queued per cycle and checked by a monitor
module tb_pipeline_hazard_ctrl;
  typedef struct packed {
    logic rst, id_ce;
    logic [4:0] rs, rt;
    logic uses_rt, md_start, hilo_rd, ex_ce, mem_read;
    logic [4:0] rd;
    logic cp;
  } in_t;
  typedef struct {
    bit          sel;
    string       nm;
    logic [10:0] exp;
  } chk_t;
  localparam logic [4:0] C0 = 5'b00000, CST = 5'b11010, CFL = 5'b00110;
  localparam logic [4:0] CMD = 5'b00001, CSTM = 5'b11011, CFLM = 5'b00111;
  logic clk = 1'b0;
  logic rst;
  chk_t q[$];
  int checks = 0, errors = 0;
  logic [3:0] exp_cnt = '0;
  pipeline_hazard_ctrl_if #(.AWIDTH(5), .CNT_WIDTH(4)) ifa ();
  pipeline_hazard_ctrl_if #(.AWIDTH(5), .CNT_WIDTH(4)) ifb ();
  pipeline_hazard_ctrl #(.AWIDTH(5), .LOAD_STALL_CYC(1), .MD_LATENCY(4), .CNT_WIDTH(4)) dut_a (
    .hc_i_clk(clk), .hc_i_rst(rst), .hc(ifa));
  pipeline_hazard_ctrl #(.AWIDTH(5), .LOAD_STALL_CYC(3), .MD_LATENCY(4), .CNT_WIDTH(4)) dut_b (
    .hc_i_clk(clk), .hc_i_rst(rst), .hc(ifb));
  always #5 clk = ~clk;
  function automatic logic [10:0] got(bit sel);
    return sel ? {ifb.hc_o_pc_stall, ifb.hc_o_ifid_stall, ifb.hc_o_ifid_flush, ifb.hc_o_idex_bubble,
                  ifb.hc_o_md_busy, ifb.hc_o_state, ifb.hc_o_stall_cnt}
               : {ifa.hc_o_pc_stall, ifa.hc_o_ifid_stall, ifa.hc_o_ifid_flush, ifa.hc_o_idex_bubble,
                  ifa.hc_o_md_busy, ifa.hc_o_state, ifa.hc_o_stall_cnt};
  endfunction
  always @(negedge clk) begin
    chk_t c;
    logic [10:0] g;
    if (q.size() != 0) begin
      c = q.pop_front();
      g = got(c.sel);
      checks++;
      if (g !== c.exp) begin
        errors++;
        $display("FAIL %s: got {ctl,state,cnt}=%b expected %b", c.nm, g, c.exp);
      end
    end
  end
  task automatic drive(input in_t v);
    rst = v.rst;
    ifa.hc_i_id_ce = v.id_ce;           ifb.hc_i_id_ce = v.id_ce;
    ifa.hc_i_id_rs = v.rs;              ifb.hc_i_id_rs = v.rs;
    ifa.hc_i_id_rt = v.rt;              ifb.hc_i_id_rt = v.rt;
    ifa.hc_i_id_uses_rt = v.uses_rt;    ifb.hc_i_id_uses_rt = v.uses_rt;
    ifa.hc_i_id_md_start = v.md_start;  ifb.hc_i_id_md_start = v.md_start;
    ifa.hc_i_id_hilo_rd = v.hilo_rd;    ifb.hc_i_id_hilo_rd = v.hilo_rd;
    ifa.hc_i_ex_ce = v.ex_ce;           ifb.hc_i_ex_ce = v.ex_ce;
    ifa.hc_i_ex_mem_read = v.mem_read;  ifb.hc_i_ex_mem_read = v.mem_read;
    ifa.hc_i_ex_rd = v.rd;              ifb.hc_i_ex_rd = v.rd;
    ifa.hc_i_ex_change_pc = v.cp;       ifb.hc_i_ex_change_pc = v.cp;
  endtask
  task automatic step(input string nm, input bit sel, input in_t v, input logic [4:0] ctl,
                      input logic [1:0] st);
    chk_t c;
    @(posedge clk);
    #1;
    drive(v);
    c.sel = sel;
    c.nm  = nm;
    c.exp = {ctl, st, v.rst ? 4'd0 : exp_cnt};
    q.push_back(c);
    if (v.rst) exp_cnt = '0;
    else if (ctl[4] && exp_cnt != 4'hf) exp_cnt = exp_cnt + 4'd1;
  endtask
  function automatic in_t rnd_rst();
    in_t v;
    v = in_t'(23'($urandom));
    v.rst = 1'b1;
    return v;
  endfunction
  function automatic in_t ld(input logic [4:0] rd, input logic [4:0] rs);
    in_t v = '0;
    v.id_ce = 1'b1; v.rs = rs; v.ex_ce = 1'b1; v.mem_read = 1'b1; v.rd = rd;
    return v;
  endfunction
  initial begin
    in_t v, nop, mdv, hi;
    nop = '0;
    mdv = '0; mdv.id_ce = 1'b1; mdv.md_start = 1'b1;
    hi  = '0; hi.id_ce = 1'b1; hi.hilo_rd = 1'b1;
    drive(rnd_rst());
    step("rst0", 0, rnd_rst(), C0, 2'd0);
    step("rst1", 0, rnd_rst(), C0, 2'd0);
    step("idle", 0, nop, C0, 2'd0);
    step("luh_rs", 0, ld(5'd8, 5'd8), CST, 2'd0);
    step("luh_after", 0, nop, C0, 2'd0);
    step("rd_zero", 0, ld(5'd0, 5'd0), C0, 2'd0);
    v = ld(5'd9, 5'd1); v.rt = 5'd9; v.uses_rt = 1'b1;
    step("luh_rt", 0, v, CST, 2'd0);
    v.uses_rt = 1'b0;
    step("rt_unused", 0, v, C0, 2'd0);
    v = ld(5'd8, 5'd8); v.ex_ce = 1'b0;
    step("ex_invalid", 0, v, C0, 2'd0);
    v = ld(5'd8, 5'd8); v.cp = 1'b1;
    step("br_over_luh", 0, v, CFL, 2'd0);
    step("br_after", 0, nop, C0, 2'd0);
    step("rst_md", 0, rnd_rst(), C0, 2'd0);
    step("md_go", 0, mdv, C0, 2'd0);
    step("md_c1", 0, nop, CMD, 2'd2);
    step("mfhi_c2", 0, hi, CSTM, 2'd2);
    step("mfhi_c3", 0, hi, CSTM, 2'd2);
    step("mfhi_c4", 0, hi, CSTM, 2'd2);
    step("mfhi_issue", 0, hi, C0, 2'd0);
    v = mdv; v.cp = 1'b1;
    step("md_br", 0, v, CFL, 2'd0);
    step("md_br_after", 0, nop, C0, 2'd0);
    step("md_go2", 0, mdv, C0, 2'd0);
    v = nop; v.cp = 1'b1;
    step("md_wait_br", 0, v, CFLM, 2'd2);
    step("md_luh", 0, ld(5'd8, 5'd8), CSTM, 2'd2);
    step("md_c3", 0, nop, CMD, 2'd2);
    step("md_c4", 0, nop, CMD, 2'd2);
    step("md_done", 0, nop, C0, 2'd0);
    step("rst_sat", 0, rnd_rst(), C0, 2'd0);
    for (int i = 0; i < 21; i++) step("sat", 0, ld(5'd8, 5'd8), CST, 2'd0);
    step("sat_hold", 0, nop, C0, 2'd0);
    step("rst_l3", 1, rnd_rst(), C0, 2'd0);
    step("l3_c0", 1, ld(5'd8, 5'd8), CST, 2'd0);
    step("l3_c1", 1, nop, CST, 2'd1);
    step("l3_c2", 1, nop, CST, 2'd1);
    step("l3_done", 1, nop, C0, 2'd0);
    step("l3_md_go", 1, mdv, C0, 2'd0);
    step("l3_md_luh", 1, ld(5'd8, 5'd8), CSTM, 2'd2);
    step("l3_md_c2", 1, nop, CSTM, 2'd2);
    step("l3_md_c3", 1, nop, CSTM, 2'd2);
    step("l3_md_c4", 1, nop, CMD, 2'd2);
    step("l3_md_done", 1, nop, C0, 2'd0);
    step("l3_rst_c0", 1, rnd_rst(), C0, 2'd0);
    step("l3_c0b", 1, ld(5'd8, 5'd8), CST, 2'd0);
    step("l3_rst_mid", 1, rnd_rst(), C0, 2'd0);
    step("l3_post_rst", 1, nop, C0, 2'd0);
    step("l3_post_rst2", 1, nop, C0, 2'd0);
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d checks pending, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
